// File: rtl/song_sequencer_if.sv
// Control, ROM and tone-generator signals of the song sequencer.
// master: the sequencer; slave: the surrounding control/ROM/tone logic.
interface song_sequencer_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned NOTE_W = 7,
    parameter int unsigned DUR_W  = 4
);
    logic                    play;
    logic                    pause;
    logic                    stop;
    logic                    loop;
    logic [ADDR_W-1:0]       rom_addr;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       note;
    logic                    playing;
    logic                    song_done;

    modport master (
        input  play, pause, stop, loop, rom_data,
        output rom_addr, note, playing, song_done
    );

    modport slave (
        output play, pause, stop, loop, rom_data,
        input  rom_addr, note, playing, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song playback controller: walks the note ROM, holds each note for its stored duration,
// handles play/pause/stop and looping. Define SONG_GAP_EN for a one-tick rest after every note.
module song_sequencer #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned NOTE_W   = 7,
    parameter int unsigned DUR_W    = 4,
    parameter int unsigned TICK_DIV = 2_500_000
) (
    input  logic             clk,
    input  logic             reset,
    song_sequencer_if.master bus
);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef SONG_GAP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSED, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSED} state_t;
`endif

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [NOTE_W-1:0]   note_q, note_nxt;
    logic [NOTE_W-1:0]   held_note, held_nxt;
    logic [DUR_W-1:0]    dur_cnt, dur_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic                playing_q, playing_nxt;
    logic                done_c;
    logic                tick_wrap;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
`ifdef SONG_GAP_EN
    logic                resume_gap, resume_gap_nxt;
`endif

    assign rom_note  = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur   = bus.rom_data[DUR_W-1:0];
    assign tick_wrap = (tick_cnt == TICK_LAST);

    // State register; all outputs except song_done come straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            note_q     <= '0;
            held_note  <= '0;
            dur_cnt    <= '0;
            tick_cnt   <= '0;
            playing_q  <= 1'b0;
`ifdef SONG_GAP_EN
            resume_gap <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            note_q     <= note_nxt;
            held_note  <= held_nxt;
            dur_cnt    <= dur_nxt;
            tick_cnt   <= tick_nxt;
            playing_q  <= playing_nxt;
`ifdef SONG_GAP_EN
            resume_gap <= resume_gap_nxt;
`endif
        end
    end

    // Next-state logic; stop outranks pause, which outranks play
    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        note_nxt       = note_q;
        held_nxt       = held_note;
        dur_nxt        = dur_cnt;
        tick_nxt       = tick_cnt;
        done_c         = 1'b0;
`ifdef SONG_GAP_EN
        resume_gap_nxt = resume_gap;
`endif
        if (bus.stop && state != S_IDLE) begin
            state_nxt = S_IDLE;
            addr_nxt  = '0;
            note_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.play) begin
                        state_nxt = S_FETCH;
                        addr_nxt  = '0;
                    end
                end
                S_FETCH: state_nxt = S_LOAD;
                S_LOAD: begin
                    if (rom_dur != '0) begin
                        note_nxt  = rom_note;
                        held_nxt  = rom_note;
                        dur_nxt   = rom_dur;
                        tick_nxt  = '0;
                        state_nxt = S_PLAY;
                    end else begin
                        done_c = 1'b1;
                        if (bus.loop) begin
                            addr_nxt  = '0;
                            state_nxt = S_FETCH;
                        end else begin
                            note_nxt  = '0;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_PLAY: begin
                    if (bus.pause) begin
                        note_nxt       = '0;
                        state_nxt      = S_PAUSED;
`ifdef SONG_GAP_EN
                        resume_gap_nxt = 1'b0;
`endif
                    end else begin
                        tick_nxt = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (tick_wrap) begin
                            dur_nxt = dur_cnt - DUR_W'(1);
                            if (dur_cnt == DUR_W'(1)) begin
                                addr_nxt = addr + ADDR_W'(1);
                                done_c   = (addr == '1);
                                if (addr == '1 && !bus.loop) begin
                                    note_nxt  = '0;
                                    state_nxt = S_IDLE;
                                end else begin
`ifdef SONG_GAP_EN
                                    note_nxt  = '0;
                                    state_nxt = S_GAP;
`else
                                    state_nxt = S_FETCH;
`endif
                                end
                            end
                        end
                    end
                end
`ifdef SONG_GAP_EN
                S_GAP: begin
                    if (bus.pause) begin
                        state_nxt      = S_PAUSED;
                        resume_gap_nxt = 1'b1;
                    end else begin
                        tick_nxt = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (tick_wrap) state_nxt = S_FETCH;
                    end
                end
`endif
                S_PAUSED: begin
                    if (bus.play) begin
`ifdef SONG_GAP_EN
                        state_nxt = resume_gap ? S_GAP : S_PLAY;
                        note_nxt  = resume_gap ? '0 : held_note;
`else
                        state_nxt = S_PLAY;
                        note_nxt  = held_note;
`endif
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // playing is registered from the next state so it tracks the state exactly
    always_comb begin
        case (state_nxt)
            S_FETCH, S_LOAD, S_PLAY: playing_nxt = 1'b1;
`ifdef SONG_GAP_EN
            S_GAP:                   playing_nxt = 1'b1;
`endif
            default:                 playing_nxt = 1'b0;
        endcase
    end

    assign bus.rom_addr  = addr;
    assign bus.note      = note_q;
    assign bus.playing   = playing_q;
    assign bus.song_done = done_c & ~reset;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer with TICK_DIV=4.
module tb_song_sequencer;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned NOTE_W   = 7;
    localparam int unsigned DUR_W    = 4;
    localparam int unsigned TICK_DIV = 4;
`ifdef SONG_GAP_EN
    localparam int GAP_CYC = TICK_DIV;
`else
    localparam int GAP_CYC = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    song_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

    song_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Registered ROM model: data valid the cycle after the address
    logic [NOTE_W+DUR_W-1:0] rom [128];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt;
    logic [6:0] exp_a [1:20];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // play pulse in cycle 0; returns at the start of cycle 1
    task automatic start();
        cyc = 0;
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
    endtask

    task automatic load_rom_a();
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = {7'h10, 4'd2};
        rom[1] = {7'h20, 4'd1};
        rom[2] = {7'h00, 4'd0};
    endtask

    initial begin
        exp_a = '{7'h00, 7'h00,
                  7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10,
                  7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20,
                  7'h00, 7'h00};
        bus.loop = 1'b0;
        load_rom_a();
        @(negedge clk);
        do_reset();
        check("rst_note", 32'(bus.note), 32'h0);
        check("rst_addr", 32'(bus.rom_addr), 32'h0);
        check("rst_playing", 32'(bus.playing), 32'h0);
        check("rst_done", 32'(bus.song_done), 32'h0);

        // ROM A, no loop: full cycle-by-cycle trace
        start();
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("a_note_c%0d", c), 32'(bus.note), 32'(exp_a[c]));
            check($sformatf("a_done_c%0d", c), 32'(bus.song_done), 32'(c == 18));
            check($sformatf("a_play_c%0d", c), 32'(bus.playing), 32'(c <= 18));
            if (c == 11) check("a_addr_c11", 32'(bus.rom_addr), 32'h1);
            tick();
        end

        // ROM A, looping: two end markers seen within 40 cycles
        do_reset();
        bus.loop = 1'b1;
        done_cnt = 0;
        start();
        for (int c = 1; c <= 40; c++) begin
            if (c == 19) check("loop_addr_c19", 32'(bus.rom_addr), 32'h0);
            if (c == 21) check("loop_note_c21", 32'(bus.note), 32'h10);
            if (c == 36) check("loop_done_c36", 32'(bus.song_done), 32'h1);
            done_cnt += int'(bus.song_done);
            tick();
        end
        check("loop_done_cnt", 32'(done_cnt), 32'd2);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("loop_stop_playing", 32'(bus.playing), 32'h0);
        bus.loop = 1'b0;

        // pause in cycle 6, resume in cycle 16: five PLAY cycles remain
        do_reset();
        start();
        run_to(6);
        check("pz_note_c6", 32'(bus.note), 32'h10);
        bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0;
        check("pz_note_c7", 32'(bus.note), 32'h0);
        check("pz_playing_c7", 32'(bus.playing), 32'h0);
        run_to(16);
        check("pz_note_c16", 32'(bus.note), 32'h0);
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
        for (int c = 17; c <= 21; c++) begin
            check($sformatf("pz_note_c%0d", c), 32'(bus.note), 32'h10);
            tick();
        end
        check("pz_addr_c22", 32'(bus.rom_addr), 32'h1);
        check("pz_note_c22", 32'(bus.note), 32'h10);
        run_to(24);
        check("pz_note_c24", 32'(bus.note), 32'h20);

        // stop and pause together during PLAY of the second note
        do_reset();
        start();
        run_to(14);
        check("sp_addr_before", 32'(bus.rom_addr), 32'h1);
        bus.stop = 1'b1; bus.pause = 1'b1;
        check("sp_done_same", 32'(bus.song_done), 32'h0);
        tick();
        bus.stop = 1'b0; bus.pause = 1'b0;
        check("sp_note", 32'(bus.note), 32'h0);
        check("sp_addr", 32'(bus.rom_addr), 32'h0);
        check("sp_playing", 32'(bus.playing), 32'h0);
        check("sp_done", 32'(bus.song_done), 32'h0);
        start();
        check("sp_restart_playing", 32'(bus.playing), 32'h1);
        check("sp_restart_note", 32'(bus.note), 32'h0);
        run_to(3);
        check("sp_restart_note_c3", 32'(bus.note), 32'h10);

        // reset (with play asserted) during PLAY of 0x20
        do_reset();
        start();
        run_to(14);
        reset = 1'b1; bus.play = 1'b1;
        tick();
        reset = 1'b0; bus.play = 1'b0;
        check("rs_note", 32'(bus.note), 32'h0);
        check("rs_addr", 32'(bus.rom_addr), 32'h0);
        check("rs_playing", 32'(bus.playing), 32'h0);
        check("rs_done", 32'(bus.song_done), 32'h0);
        start();
        check("rs_restart_addr", 32'(bus.rom_addr), 32'h0);
        run_to(3);
        check("rs_restart_note", 32'(bus.note), 32'h10);

        // all 128 entries with dur=1: end reached on address wrap
        for (int i = 0; i < 128; i++) rom[i] = {(i == 0) ? 7'h01 : 7'(i), 4'd1};
        do_reset();
        done_cnt = 0;
        start();
        begin
            int period;
            int done_at;
            period  = 6 + GAP_CYC;
            done_at = 6 + 127 * period;
            for (int c = 1; c <= done_at + 6; c++) begin
                if (c == 7) check("all_note_c7", 32'(bus.note), (GAP_CYC != 0) ? 32'h0 : 32'h1);
                if (c == 3 + 64 * period) check("all_note_64", 32'(bus.note), 32'd64);
                if (c == 3 + 127 * period) check("all_note_127", 32'(bus.note), 32'd127);
                if (c == done_at) check("all_done", 32'(bus.song_done), 32'h1);
                if (c == done_at + 1) begin
                    check("all_end_note", 32'(bus.note), 32'h0);
                    check("all_end_playing", 32'(bus.playing), 32'h0);
                    check("all_end_addr", 32'(bus.rom_addr), 32'h0);
                end
                done_cnt += int'(bus.song_done);
                tick();
            end
        end
        check("all_done_cnt", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
